// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with branch/jump/exception redirect,
// hazard stall, debug run/step/halt control and return-address taps.
module pc_unit #(
    parameter int unsigned     NB         = 32,
    parameter logic [NB-1:0]   RESET_PC   = '0,
    parameter int unsigned     PC_INC     = 4,
    parameter logic [31:0]     EXC_VECTOR = 32'h80,
    parameter int unsigned     CNT_NB     = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_mode_step,
    input  logic              i_step,
    input  logic              i_resume,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [NB-1:0]     i_branch_target,
    input  logic              i_jump,
    input  logic [NB-1:0]     i_jump_target,
    input  logic              i_exception,
    input  logic              i_halt_instr,
    output logic [NB-1:0]     o_pc,
    output logic [NB-1:0]     o_pc_4,
    output logic [NB-1:0]     o_pc_8,
    output logic              o_fetch_valid,
    output logic              o_halted,
    output logic [1:0]        o_state,
    output logic [CNT_NB-1:0] o_fetch_count
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STEP_WAIT = 2'd1,
        ST_HALTED    = 2'd2
    } state_t;

    localparam logic [NB-1:0] INC1   = NB'(PC_INC);
    localparam logic [NB-1:0] INC2   = NB'(2 * PC_INC);
    localparam logic [NB-1:0] EXC_PC = NB'(EXC_VECTOR);

    state_t            state_q, state_d;
    logic [NB-1:0]     pc_q, pc_d;
    logic [CNT_NB-1:0] cnt_q, cnt_d;

    logic active;
    logic adv;
    logic redir;
    logic halt_entry;

    // Fetch/redirect qualifiers; HALTED masks every request.
    always_comb begin
        active     = (state_q == ST_RUN) || (state_q == ST_STEP_WAIT);
        adv        = !i_stall &&
                     ((state_q == ST_RUN) || ((state_q == ST_STEP_WAIT) && i_step));
        redir      = active && (i_exception || i_jump || i_branch_taken);
        halt_entry = adv && i_halt_instr && !redir;
    end

    // Next-PC selection: exception > jump > branch > sequential > hold.
    always_comb begin
        pc_d = pc_q;
        if (active) begin
            if (i_exception) begin
                pc_d = EXC_PC;
            end else if (i_jump) begin
                pc_d = i_jump_target;
            end else if (i_branch_taken) begin
                pc_d = i_branch_target;
            end else if (adv && !i_halt_instr) begin
                pc_d = pc_q + INC1;
            end
        end
    end

    // Debug state machine; HALT entry outranks a mode switch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_entry) begin
                    state_d = ST_HALTED;
                end else if (i_mode_step) begin
                    state_d = ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (halt_entry) begin
                    state_d = ST_HALTED;
                end else if (!i_mode_step) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (i_resume) begin
                    state_d = i_mode_step ? ST_STEP_WAIT : ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Fetch counter advances on every consumed fetch, wrapping naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (adv) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Architectural registers with asynchronous active-low reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_pc_4        = pc_q + INC1;
    assign o_pc_8        = pc_q + INC2;
    assign o_fetch_valid = adv;
    assign o_halted      = (state_q == ST_HALTED);
    assign o_state       = state_q;
    assign o_fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: two instances (default and wrap-around reset PC with
// a 2-bit counter) share stimulus; a cycle model feeds a scoreboard queue.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        mode_step, step, resume, stall;
    logic        br, jump, exc, halt;
    logic [31:0] bt, jt;

    logic [31:0] pc_a, pc4_a, pc8_a, cnt_a;
    logic        fv_a, hlt_a;
    logic [1:0]  st_a;
    logic [31:0] pc_b, pc4_b, pc8_b;
    logic [1:0]  cnt_b;
    logic        fv_b, hlt_b;
    logic [1:0]  st_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  st;
        logic [31:0] cnt;
    } mstate_t;

    typedef struct {
        mstate_t a;
        mstate_t b;
    } exp_t;

    exp_t    sb[$];
    mstate_t ma, mb;

    pc_unit dut_a (
        .i_clock(clk), .i_reset(rst_n), .i_mode_step(mode_step), .i_step(step),
        .i_resume(resume), .i_stall(stall), .i_branch_taken(br),
        .i_branch_target(bt), .i_jump(jump), .i_jump_target(jt),
        .i_exception(exc), .i_halt_instr(halt), .o_pc(pc_a), .o_pc_4(pc4_a),
        .o_pc_8(pc8_a), .o_fetch_valid(fv_a), .o_halted(hlt_a),
        .o_state(st_a), .o_fetch_count(cnt_a)
    );

    pc_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_NB(2)) dut_b (
        .i_clock(clk), .i_reset(rst_n), .i_mode_step(mode_step), .i_step(step),
        .i_resume(resume), .i_stall(stall), .i_branch_taken(br),
        .i_branch_target(bt), .i_jump(jump), .i_jump_target(jt),
        .i_exception(exc), .i_halt_instr(halt), .o_pc(pc_b), .o_pc_4(pc4_b),
        .o_pc_8(pc8_b), .o_fetch_valid(fv_b), .o_halted(hlt_b),
        .o_state(st_b), .o_fetch_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic madv(mstate_t s);
        return !stall && ((s.st == 2'd0) || ((s.st == 2'd1) && step));
    endfunction

    function automatic mstate_t mnext(mstate_t s, logic [31:0] cmask);
        mstate_t n = s;
        logic    a = madv(s);
        logic    r = exc || jump || br;
        if (s.st == 2'd2) begin
            if (resume) n.st = mode_step ? 2'd1 : 2'd0;
            return n;
        end
        if (exc)                 n.pc = 32'h80;
        else if (jump)           n.pc = jt;
        else if (br)             n.pc = bt;
        else if (a && !halt)     n.pc = s.pc + 32'd4;
        if (a && halt && !r)                   n.st = 2'd2;
        else if ((s.st == 2'd0) && mode_step)  n.st = 2'd1;
        else if ((s.st == 2'd1) && !mode_step) n.st = 2'd0;
        if (a) n.cnt = (s.cnt + 32'd1) & cmask;
        return n;
    endfunction

    task automatic model_reset();
        ma = '{pc: 32'h0, st: 2'd0, cnt: 32'h0};
        mb = '{pc: 32'hFFFF_FFFC, st: 2'd0, cnt: 32'h0};
        sb.delete();
    endtask

    // One clock: check combinational taps, push the model's prediction,
    // clock the DUTs, then pop and compare the registered outputs.
    task automatic cyc();
        exp_t        e;
        logic [31:0] x4, x8;
        #2;
        check_eq("fv_a", {63'd0, fv_a}, {63'd0, madv(ma)});
        check_eq("fv_b", {63'd0, fv_b}, {63'd0, madv(mb)});
        x4 = ma.pc + 32'd4; x8 = ma.pc + 32'd8;
        check_eq("pc4_a", {32'd0, pc4_a}, {32'd0, x4});
        check_eq("pc8_a", {32'd0, pc8_a}, {32'd0, x8});
        x4 = mb.pc + 32'd4; x8 = mb.pc + 32'd8;
        check_eq("pc4_b", {32'd0, pc4_b}, {32'd0, x4});
        check_eq("pc8_b", {32'd0, pc8_b}, {32'd0, x8});
        check_eq("halted_a", {63'd0, hlt_a}, {63'd0, (ma.st == 2'd2)});
        sb.push_back('{a: mnext(ma, 32'hFFFF_FFFF), b: mnext(mb, 32'h3)});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_eq("pc_a", {32'd0, pc_a}, {32'd0, e.a.pc});
            check_eq("st_a", {62'd0, st_a}, {62'd0, e.a.st});
            check_eq("cnt_a", {32'd0, cnt_a}, {32'd0, e.a.cnt});
            check_eq("pc_b", {32'd0, pc_b}, {32'd0, e.b.pc});
            check_eq("st_b", {62'd0, st_b}, {62'd0, e.b.st});
            check_eq("cnt_b", {62'd0, cnt_b}, {32'd0, e.b.cnt});
            ma = e.a;
            mb = e.b;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cnt_save;
        rst_n = 1'b0;
        {mode_step, step, resume, stall, br, jump, exc, halt} = '0;
        bt = '0; jt = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pc_a", {32'd0, pc_a}, 64'h0);
        check_eq("rst_st_a", {62'd0, st_a}, 64'h0);
        check_eq("rst_cnt_a", {32'd0, cnt_a}, 64'h0);
        check_eq("rst_fv_a", {63'd0, fv_a}, 64'h1);
        check_eq("rst_pc_b", {32'd0, pc_b}, 64'hFFFF_FFFC);
        check_eq("rst_pc8_b", {32'd0, pc8_b}, 64'h4);
        rst_n = 1'b1;

        // Free run for 4 cycles
        repeat (4) cyc();
        check_eq("run_pc", {32'd0, pc_a}, 64'h10);
        check_eq("run_pc4", {32'd0, pc4_a}, 64'h14);
        check_eq("run_pc8", {32'd0, pc8_a}, 64'h18);
        check_eq("run_cnt", {32'd0, cnt_a}, 64'h4);

        // Stall holds, branch under stall still redirects
        stall = 1'b1;
        repeat (2) cyc();
        check_eq("stall_pc", {32'd0, pc_a}, 64'h10);
        br = 1'b1; bt = 32'h40;
        cyc();
        check_eq("br_stall_pc", {32'd0, pc_a}, 64'h40);
        stall = 1'b0;
        exc = 1'b1; jump = 1'b1; jt = 32'h100; bt = 32'h200;
        cyc();
        check_eq("prio_pc", {32'd0, pc_a}, 64'h80);
        {exc, jump, br} = '0;

        // Jump to 0x8 while entering step mode, then wait for a step pulse
        jump = 1'b1; jt = 32'h8; mode_step = 1'b1;
        cyc();
        jump = 1'b0;
        check_eq("step_st", {62'd0, st_a}, 64'h1);
        repeat (5) cyc();
        check_eq("step_hold_pc", {32'd0, pc_a}, 64'h8);
        cnt_save = cnt_a;
        step = 1'b1;
        cyc();
        step = 1'b0;
        check_eq("step_pc", {32'd0, pc_a}, 64'hC);
        check_eq("step_cnt", {32'd0, cnt_a}, {32'd0, cnt_save + 32'd1});

        // Back to run, go to 0x24 and halt there
        mode_step = 1'b0;
        cyc();
        jump = 1'b1; jt = 32'h24;
        cyc();
        jump = 1'b0; halt = 1'b1;
        cyc();
        check_eq("halt_st", {62'd0, st_a}, 64'h2);
        check_eq("halt_pc", {32'd0, pc_a}, 64'h24);
        br = 1'b1; bt = 32'h200; step = 1'b1; exc = 1'b1;
        repeat (2) cyc();
        {br, step, exc} = '0;
        check_eq("halt_ign_pc", {32'd0, pc_a}, 64'h24);
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        check_eq("resume_st", {62'd0, st_a}, 64'h0);
        check_eq("resume_pc", {32'd0, pc_a}, 64'h24);
        halt = 1'b0;
        cyc();
        check_eq("post_resume_pc", {32'd0, pc_a}, 64'h28);

        // Halt again, then async reset mid-cycle with a jump pending
        halt = 1'b1;
        cyc();
        check_eq("halt2_st", {62'd0, st_a}, 64'h2);
        jump = 1'b1; jt = 32'h300;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_pc_a", {32'd0, pc_a}, 64'h0);
        check_eq("arst_st_a", {62'd0, st_a}, 64'h0);
        check_eq("arst_cnt_a", {32'd0, cnt_a}, 64'h0);
        check_eq("arst_pc_b", {32'd0, pc_b}, 64'hFFFF_FFFC);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        jump = 1'b0; halt = 1'b0;

        // Wrap of PC and 2-bit counter on the second instance
        cyc();
        check_eq("wrap_pc_b", {32'd0, pc_b}, 64'h0);
        repeat (4) cyc();
        check_eq("wrap_cnt_b", {62'd0, cnt_b}, 64'h1);
        check_eq("after_rst_pc_a", {32'd0, pc_a}, 64'h14);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
